// File: rtl/vending_machine_param.sv
// Parametrised vending controller: three coin values, saturating credit,
// price/dispense handshake, unit change pulses, cancel refund, stock count.
//
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   coin_a, coin_b, coin_c       one-cycle coin pulses (VAL_A/B/C)
//   cancel                       refund request (honoured in COLLECT)
//   dispense_ack                 dispenser released the item
//   restock                      reload stock (honoured in IDLE)
//   dispense                     item release request, Moore (VEND)
//   change_pulse                 one cycle per change unit, Moore (CHANGE)
//   coin_reject                  last sampled coin was not credited
//   sold_out                     stock == 0
//   credit, stock                current credit and items remaining
module vending_machine_param #(
    parameter int PRICE      = 5,
    parameter int CREDIT_W   = 4,
    parameter int VAL_A      = 1,
    parameter int VAL_B      = 2,
    parameter int VAL_C      = 5,
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin_a,
    input  logic                coin_b,
    input  logic                coin_c,
    input  logic                cancel,
    input  logic                dispense_ack,
    input  logic                restock,
    output logic                dispense,
    output logic                change_pulse,
    output logic                coin_reject,
    output logic                sold_out,
    output logic [CREDIT_W-1:0] credit,
    output logic [STOCK_W-1:0]  stock
);

    // One extra bit so credit + coin value can never wrap.
    localparam int VW = CREDIT_W + 1;

    localparam logic [VW-1:0] CMAX    = VW'((1 << CREDIT_W) - 1);
    localparam logic [VW-1:0] PRICE_V = VW'(PRICE);
    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [STOCK_W-1:0]  STOCK_I = STOCK_W'(STOCK_INIT);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        VEND,
        CHANGE
    } state_t;

    state_t state;

    logic          coin_any;
    logic          coin_one;
    logic [VW-1:0] val;
    logic [VW-1:0] sum;
    logic          accept;
    logic [CREDIT_W-1:0] rem;

    assign coin_any = coin_a | coin_b | coin_c;
    assign coin_one = (32'(coin_a) + 32'(coin_b) + 32'(coin_c)) == 32'd1;

    always_comb begin
        val = '0;
        if (coin_a)
            val = VW'(VAL_A);
        else if (coin_b)
            val = VW'(VAL_B);
        else if (coin_c)
            val = VW'(VAL_C);
    end

    assign sum = {1'b0, credit} + val;
    assign rem = credit - PRICE_C;

    assign accept = ((state == IDLE) || (state == COLLECT))
                    && (stock != '0)
                    && coin_one
                    && !cancel
                    && (sum <= CMAX);

    assign dispense     = (state == VEND);
    assign change_pulse = (state == CHANGE);
    assign sold_out     = (stock == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            credit      <= '0;
            stock       <= STOCK_I;
            coin_reject <= 1'b0;
        end else begin
            coin_reject <= coin_any && !accept;
            unique case (state)
                IDLE, COLLECT: begin
                    if (state == IDLE && restock)
                        stock <= STOCK_I;
                    if (accept) begin
                        credit <= sum[CREDIT_W-1:0];
                        state  <= (sum >= PRICE_V) ? VEND : COLLECT;
                    end else if (state == COLLECT && cancel) begin
                        state <= CHANGE;
                    end
                end
                VEND: begin
                    if (dispense_ack) begin
                        credit <= rem;
                        stock  <= stock - STOCK_W'(1);
                        state  <= (rem != '0) ? CHANGE : IDLE;
                    end
                end
                CHANGE: begin
                    credit <= credit - CREDIT_W'(1);
                    if (credit == CREDIT_W'(1))
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vending_machine_param.sv
// Directed bench for vending_machine_param: default instance plus a
// PRICE=14 instance for the saturation / exact-price case.
module tb_vending_machine_param;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic coin_a = 0, coin_b = 0, coin_c = 0;
    logic cancel = 0, dispense_ack = 0, restock = 0;
    logic dispense, change_pulse, coin_reject, sold_out;
    logic [3:0] credit, stock;

    logic h_a = 0, h_b = 0, h_c = 0;
    logic h_cancel = 0, h_ack = 0, h_restock = 0;
    logic h_disp, h_chg, h_rej, h_so;
    logic [3:0] h_credit, h_stock;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vending_machine_param dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .coin_a       (coin_a),
        .coin_b       (coin_b),
        .coin_c       (coin_c),
        .cancel       (cancel),
        .dispense_ack (dispense_ack),
        .restock      (restock),
        .dispense     (dispense),
        .change_pulse (change_pulse),
        .coin_reject  (coin_reject),
        .sold_out     (sold_out),
        .credit       (credit),
        .stock        (stock)
    );

    vending_machine_param #(.PRICE(14)) dut14 (
        .clk          (clk),
        .rst_n        (rst_n),
        .coin_a       (h_a),
        .coin_b       (h_b),
        .coin_c       (h_c),
        .cancel       (h_cancel),
        .dispense_ack (h_ack),
        .restock      (h_restock),
        .dispense     (h_disp),
        .change_pulse (h_chg),
        .coin_reject  (h_rej),
        .sold_out     (h_so),
        .credit       (h_credit),
        .stock        (h_stock)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Counts consecutive high cycles of change_pulse, bounded.
    task automatic count_chg(output int n);
        n = 0;
        while (change_pulse && n < 20) begin
            n++;
            tick();
        end
    endtask

    task automatic vend_c;
        coin_c = 1; tick(); coin_c = 0;
        dispense_ack = 1; tick(); dispense_ack = 0;
    endtask

    int n;
    int d;

    initial begin
        tick(); tick();
        chk("rst_credit", credit, 0);
        chk("rst_stock", stock, 4);
        chk("rst_disp", dispense, 0);
        chk("rst_chg", change_pulse, 0);
        chk("rst_rej", coin_reject, 0);
        chk("rst_sold", sold_out, 0);
        rst_n = 1; tick();

        // 1: three coin_b, ack two cycles after dispense rises
        coin_b = 1; tick(); coin_b = 0;
        chk("t1_cr2", credit, 2);
        tick();
        coin_b = 1; tick(); coin_b = 0;
        chk("t1_cr4", credit, 4);
        coin_b = 1; tick(); coin_b = 0;
        chk("t1_cr6", credit, 6);
        d = 0;
        for (int i = 0; i < 3; i++) begin
            if (dispense) d++;
            if (i == 2) dispense_ack = 1;
            tick();
        end
        dispense_ack = 0;
        chk("t1_disp_cycles", d, 3);
        chk("t1_disp_off", dispense, 0);
        count_chg(n);
        chk("t1_chg_cycles", n, 1);
        chk("t1_credit", credit, 0);
        chk("t1_stock", stock, 3);

        // 2: exact price, no change
        coin_c = 1; tick(); coin_c = 0;
        chk("t2_disp", dispense, 1);
        dispense_ack = 1; tick(); dispense_ack = 0;
        chk("t2_chg", change_pulse, 0);
        chk("t2_disp_off", dispense, 0);
        chk("t2_credit", credit, 0);
        chk("t2_stock", stock, 2);

        // 3: cancel refund
        coin_a = 1; tick(); coin_a = 0;
        coin_b = 1; tick(); coin_b = 0;
        chk("t3_cr3", credit, 3);
        cancel = 1; tick(); cancel = 0;
        chk("t3_disp", dispense, 0);
        count_chg(n);
        chk("t3_chg_cycles", n, 3);
        chk("t3_credit", credit, 0);
        chk("t3_stock", stock, 2);

        // 4: rejections
        coin_a = 1; coin_b = 1; tick(); coin_a = 0; coin_b = 0;
        chk("t4_rej_multi", coin_reject, 1);
        chk("t4_cr_multi", credit, 0);
        tick();
        chk("t4_rej_clear", coin_reject, 0);
        coin_c = 1; tick(); coin_c = 0;
        chk("t4_rej_ok", coin_reject, 0);
        coin_a = 1; tick(); coin_a = 0;
        chk("t4_rej_vend", coin_reject, 1);
        chk("t4_cr_vend", credit, 5);
        cancel = 1; tick(); cancel = 0;
        chk("t4_cancel_vend", dispense, 1);
        dispense_ack = 1; tick(); dispense_ack = 0;
        chk("t4_stock", stock, 1);
        coin_a = 1; cancel = 1; tick(); coin_a = 0; cancel = 0;
        chk("t4_rej_cancel", coin_reject, 1);
        chk("t4_cr_cancel", credit, 0);

        // 6: sell out and restock
        restock = 1; tick(); restock = 0;
        chk("t6_restock1", stock, 4);
        for (int i = 0; i < 4; i++) vend_c();
        chk("t6_stock0", stock, 0);
        chk("t6_sold", sold_out, 1);
        coin_a = 1; tick(); coin_a = 0;
        chk("t6_rej_sold", coin_reject, 1);
        chk("t6_cr_sold", credit, 0);
        restock = 1; tick(); restock = 0;
        chk("t6_restock2", stock, 4);
        chk("t6_unsold", sold_out, 0);

        // 6b: async reset mid-CHANGE
        coin_c = 1; tick(); coin_c = 0;
        coin_b = 1; tick(); coin_b = 0;
        chk("t6b_rej_vend", coin_reject, 1);
        chk("t6b_cr", credit, 5);
        coin_c = 0;
        dispense_ack = 1; tick(); dispense_ack = 0;
        tick();
        chk("t6b_idle", change_pulse, 0);
        coin_c = 1; tick(); coin_c = 0;
        coin_b = 1; tick(); coin_b = 0;
        chk("t6b_cr7", credit, 5);
        dispense_ack = 1; tick(); dispense_ack = 0;
        chk("t6b_stock", stock, 2);
        coin_b = 0;
        rst_n = 1;
        if (!change_pulse) begin
            // second vend had no change (coin_b rejected in VEND);
            // build a change case explicitly
            coin_b = 1; tick(); coin_b = 0;
            coin_b = 1; tick(); coin_b = 0;
            coin_b = 1; tick(); coin_b = 0;
            dispense_ack = 1; tick(); dispense_ack = 0;
        end
        chk("t6b_in_chg", change_pulse, 1);
        #2 rst_n = 0;
        #1;
        chk("t6b_rst_chg", change_pulse, 0);
        chk("t6b_rst_cr", credit, 0);
        chk("t6b_rst_stock", stock, 4);
        tick();
        rst_n = 1; tick();

        // 5: PRICE=14 saturation
        h_c = 1; tick(); h_c = 0;
        h_c = 1; tick(); h_c = 0;
        h_b = 1; tick(); h_b = 0;
        chk("t5_cr12", h_credit, 12);
        h_c = 1; tick(); h_c = 0;
        chk("t5_rej_sat", h_rej, 1);
        chk("t5_cr_sat", h_credit, 12);
        h_b = 1; tick(); h_b = 0;
        chk("t5_cr14", h_credit, 14);
        chk("t5_disp", h_disp, 1);
        h_ack = 1; tick(); h_ack = 0;
        chk("t5_chg", h_chg, 0);
        chk("t5_cr0", h_credit, 0);
        chk("t5_stock", h_stock, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
